// File: rtl/dbg_step_ctrl.sv
// dbg_step_ctrl -- single-step / run / breakpoint controller for a soft CPU.
//
// Two pushbuttons are turned into one-cycle press events. Each button goes
// through a two-flop synchronizer and a stability-count debouncer. The events
// drive a three-state FSM (HALT, RUN, BREAK). The FSM produces the CPU clock
// enable and counts executed instructions.
//
// Optional feature: define DBG_STEP_BP_EN to compile in the PC breakpoint.
// Without it, bp_addr/bp_en are ignored and BREAK can never be entered.
//
// Ports
//   clk          single clock for all logic
//   reset        synchronous, active-high reset
//   key_step_n   raw asynchronous step button, active low
//   key_run_n    raw asynchronous run/pause toggle button, active low
//   sw_fast      1 = run at full speed, 0 = one instruction per RUN_DIV cycles
//   pc           current CPU program counter
//   bp_addr      breakpoint address
//   bp_en        breakpoint enable
//   cpu_en       registered CPU clock enable (one instruction per high cycle)
//   run_state    00 HALT, 01 RUN, 10 BREAK
//   instr_count  number of cpu_en high cycles, wraps at 16 bits
module dbg_step_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int RUN_DIV    = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_step_n,
  input  logic        key_run_n,
  input  logic        sw_fast,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  output logic        cpu_en,
  output logic [1:0]  run_state,
  output logic [15:0] instr_count
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BREAK = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Key conditioning: index 0 = step, index 1 = run.
  // ---------------------------------------------------------------------------
  logic [1:0] key_raw;
  logic [1:0] press;

  assign key_raw = {key_run_n, key_step_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             level_reg;
      logic             press_reg;
      logic [DEB_W-1:0] cnt_reg;

      // The counter only runs while the synchronized input disagrees with the
      // accepted level. Agreement at any point means the input bounced back,
      // so the count restarts from zero.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          level_reg <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
            // Only the falling (pressed) edge of the level is an event.
            press_reg <= ~sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + DEB_W'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic press_step;
  logic press_run;

  assign press_step = press[0];
  assign press_run  = press[1];

  // ---------------------------------------------------------------------------
  // Run FSM
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             skip_reg;
  logic             skip_next;
  logic             cpu_en_reg;
  logic             cpu_en_next;
  logic [15:0]      count_reg;

  logic div_wrap;
  logic run_fire;
  logic bp_hit;

  // The divider keeps counting in RUN even at full speed. A switch back to
  // slow mode then continues the same RUN_DIV cadence.
  assign div_wrap = (div_reg == DIV_LAST);
  assign run_fire = sw_fast | div_wrap;

`ifdef DBG_STEP_BP_EN
  // The skip flag lets the instruction sitting on the breakpoint execute
  // once after resuming from BREAK.
  assign bp_hit = bp_en && (pc == bp_addr) && !skip_reg;
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_en};
  assign bp_hit    = 1'b0;
`endif

  // State register (all outputs are registered here as well).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_HALT;
      div_reg    <= '0;
      skip_reg   <= 1'b0;
      cpu_en_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      skip_reg   <= skip_next;
      cpu_en_reg <= cpu_en_next;
      count_reg  <= count_reg + 16'(cpu_en_reg);
    end
  end

  // Next-state logic. A run press always wins over a step press.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    skip_next  = skip_reg;
    case (state_reg)
      ST_HALT, ST_BREAK: begin
        if (press_run) begin
          state_next = ST_RUN;
          div_next   = '0;
          skip_next  = (state_reg == ST_BREAK);
        end else if (press_step) begin
          state_next = ST_HALT;
        end
      end
      ST_RUN: begin
        div_next = div_wrap ? '0 : div_reg + DIV_W'(1);
        if (press_run) begin
          state_next = ST_HALT;
        end else if (run_fire && bp_hit) begin
          state_next = ST_BREAK;
        end else if (run_fire) begin
          skip_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  // Output logic: value cpu_en takes in the following cycle.
  always_comb begin
    cpu_en_next = 1'b0;
    case (state_reg)
      ST_HALT, ST_BREAK: cpu_en_next = press_step & ~press_run;
      ST_RUN:            cpu_en_next = ~press_run & run_fire & ~bp_hit;
      default:           cpu_en_next = 1'b0;
    endcase
  end

  assign cpu_en      = cpu_en_reg;
  assign run_state   = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Testbench for dbg_step_ctrl with DEB_CYCLES=4 and RUN_DIV=8.
// Three parts: a table of hold-inputs phases with hand-derived expectations,
// hand-written multi-cycle sequences (counter wrap, breakpoint), and random
// stimulus compared against a windowed reference model.
module tb_dbg_step_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;
  localparam int HL  = DEB + 2;   // raw history: 2 sync stages + stability window

  logic        clk;
  logic        reset;
  logic        key_step_n;
  logic        key_run_n;
  logic        sw_fast;
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        bp_en;
  logic        cpu_en;
  logic [1:0]  run_state;
  logic [15:0] instr_count;

  dbg_step_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_step_n  (key_step_n),
    .key_run_n   (key_run_n),
    .sw_fast     (sw_fast),
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .cpu_en      (cpu_en),
    .run_state   (run_state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. A key level is accepted when the last DEB synchronized
  // samples (raw delayed by two edges) all disagree with the current level.
  // Slow-run pulses fall on multiples of DIV edges counted from RUN entry.
  // ---------------------------------------------------------------------------
  bit        hs [HL];
  bit        hr [HL];
  bit        deb_s, deb_r, ev_s, ev_r;
  int        m_state;
  bit        m_cpu;
  bit [15:0] m_cnt;
  int        m_n;
  bit        m_skip;

  function automatic bit win_all(input bit a [HL], input bit v);
    for (int i = 2; i < HL; i++) if (a[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit fire, hit, cpu_new;
    if (reset) begin
      for (int i = 0; i < HL; i++) begin
        hs[i] = 1'b1;
        hr[i] = 1'b1;
      end
      deb_s = 1'b1; deb_r = 1'b1; ev_s = 1'b0; ev_r = 1'b0;
      m_state = 0; m_cpu = 1'b0; m_cnt = '0; m_n = 0; m_skip = 1'b0;
      return;
    end
    m_cnt   = m_cnt + 16'(m_cpu);
    cpu_new = 1'b0;
    if (m_state != 1) begin
      if (ev_r) begin
        m_skip  = (m_state == 2);
        m_state = 1;
        m_n     = 0;
      end else if (ev_s) begin
        cpu_new = 1'b1;
        m_state = 0;
      end
    end else begin
      m_n++;
      fire = sw_fast || (m_n % DIV == 0);
      hit  = 1'b0;
`ifdef DBG_STEP_BP_EN
      hit = bp_en && (pc == bp_addr) && !m_skip;
`endif
      if (ev_r) m_state = 0;
      else if (fire && hit) m_state = 2;
      else if (fire) begin
        cpu_new = 1'b1;
        m_skip  = 1'b0;
      end
    end
    m_cpu = cpu_new;
    for (int i = HL - 1; i > 0; i--) begin
      hs[i] = hs[i-1];
      hr[i] = hr[i-1];
    end
    hs[0] = key_step_n;
    hr[0] = key_run_n;
    ev_s = 1'b0;
    if (win_all(hs, !deb_s)) begin
      deb_s = !deb_s;
      ev_s  = !deb_s;
    end
    ev_r = 1'b0;
    if (win_all(hr, !deb_r)) begin
      deb_r = !deb_r;
      ev_r  = !deb_r;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Phase table
  // ---------------------------------------------------------------------------
  typedef struct {
    int        cycles;
    bit        ks;
    bit        kr;
    bit        sw;
    bit        rst;
    bit [1:0]  st;
    bit [15:0] cnt;
    int        pulses;
  } vec_t;

  function automatic vec_t mk(input int c, input bit ks, input bit kr, input bit sw,
                              input bit rst, input bit [1:0] st, input bit [15:0] cnt,
                              input int p);
    vec_t v;
    v.cycles = c; v.ks = ks; v.kr = kr; v.sw = sw; v.rst = rst;
    v.st = st; v.cnt = cnt; v.pulses = p;
    return v;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   pulses;
    bit   got;
    logic [31:0] pc_at;

    reset = 1'b1; key_step_n = 1'b1; key_run_n = 1'b1; sw_fast = 1'b0;
    pc = '0; bp_addr = 32'h10; bp_en = 1'b0;

    //                cyc ks kr sw rst st cnt pulses
    tbl.push_back(mk(3,  1, 1, 0, 1, 0, 0,  0));   // reset state
    for (int i = 0; i < 5; i++) begin             // bouncing step key
      tbl.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2, 1, 1, 0, 0, 0, 0, 0));
    end
    tbl.push_back(mk(20, 0, 1, 0, 0, 0, 1,  1));   // one step
    tbl.push_back(mk(10, 1, 1, 0, 0, 0, 1,  0));   // release: no event
    tbl.push_back(mk(8,  1, 0, 0, 0, 1, 1,  0));   // run press, slow
    tbl.push_back(mk(40, 1, 1, 0, 0, 1, 6,  5));   // pulse every 8 cycles
    tbl.push_back(mk(8,  1, 0, 0, 0, 0, 6,  0));   // run press -> HALT, due pulse dropped
    tbl.push_back(mk(10, 1, 1, 0, 0, 0, 6,  0));
    tbl.push_back(mk(8,  0, 0, 1, 0, 1, 6,  1));   // step+run together -> RUN, no step
    tbl.push_back(mk(10, 1, 1, 1, 0, 1, 16, 10));  // fast run
    tbl.push_back(mk(1,  1, 1, 1, 1, 0, 0,  0));   // reset during RUN
    tbl.push_back(mk(10, 1, 1, 1, 0, 0, 0,  0));   // nothing after reset
    tbl.push_back(mk(5,  0, 1, 0, 0, 0, 0,  0));   // step mid-debounce
    tbl.push_back(mk(1,  0, 1, 0, 1, 0, 0,  0));   // reset on the accept edge
    tbl.push_back(mk(12, 1, 1, 0, 0, 0, 0,  0));   // pending press discarded

    foreach (tbl[r]) begin
      key_step_n = tbl[r].ks; key_run_n = tbl[r].kr;
      sw_fast = tbl[r].sw; reset = tbl[r].rst;
      pulses = 0;
      for (int c = 0; c < tbl[r].cycles; c++) begin
        @(negedge clk);
        if (cpu_en) pulses++;
      end
      check($sformatf("row%0d run_state", r), 32'(run_state), 32'(tbl[r].st));
      check($sformatf("row%0d instr_count", r), 32'(instr_count), 32'(tbl[r].cnt));
      check($sformatf("row%0d pulses", r), 32'(pulses), 32'(tbl[r].pulses));
      $display("row %0d: ks=%0b kr=%0b sw=%0b rst=%0b cycles=%0d -> state=%0d count=%0d pulses=%0d",
               r, tbl[r].ks, tbl[r].kr, tbl[r].sw, tbl[r].rst, tbl[r].cycles,
               run_state, instr_count, pulses);
    end

    // Counter wrap: 65538 edges after RUN entry at full speed -> 65537 pulses counted.
    reset = 1'b1; key_step_n = 1'b1; key_run_n = 1'b1; sw_fast = 1'b1; bp_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; key_run_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (run_state == 2'b01) break;
    end
    check("wrap run entry", 32'(run_state), 32'h1);
    key_run_n = 1'b1;
    for (int j = 1; j <= 65538; j++) begin
      @(negedge clk);
      if (j == 65536) check("wrap count ffff", 32'(instr_count), 32'hFFFF);
    end
    check("wrap count 1", 32'(instr_count), 32'h1);
    $display("wrap: instr_count=%0h", instr_count);

`ifdef DBG_STEP_BP_EN
    // Breakpoint at 0x10, pc advances by 4 per executed instruction.
    reset = 1'b1; key_run_n = 1'b1; sw_fast = 1'b1; bp_en = 1'b1; bp_addr = 32'h10; pc = '0;
    @(negedge clk);
    reset = 1'b0; key_run_n = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (cpu_en) begin
        pulses++;
        pc = pc + 32'd4;
      end
      if (run_state == 2'b10) break;
    end
    check("bp state", 32'(run_state), 32'h2);
    check("bp pulses", 32'(pulses), 32'd4);
    check("bp pc", pc, 32'h10);
    check("bp count", 32'(instr_count), 32'd4);
    key_run_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpu_en) pulses++;
    end
    check("bp held pulses", 32'(pulses), 32'd0);
    check("bp held state", 32'(run_state), 32'h2);
    key_run_n = 1'b0;
    got = 1'b0; pc_at = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_en) begin
        got = 1'b1; pc_at = pc;
        pc = pc + 32'd4;
        break;
      end
    end
    check("bp resume pulse", 32'(got), 32'h1);
    check("bp resume pc", pc_at, 32'h10);
    key_run_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cpu_en) begin
        pulses++;
        pc = pc + 32'd4;
      end
    end
    check("bp after resume pulses", 32'(pulses), 32'd5);
    check("bp after resume state", 32'(run_state), 32'h1);
    $display("breakpoint: pc=%0h state=%0d count=%0d", pc, run_state, instr_count);
`endif

    // Random segments against the reference model.
    reset = 1'b1; key_step_n = 1'b1; key_run_n = 1'b1; sw_fast = 1'b0;
    bp_addr = 32'h10; bp_en = 1'b0; pc = 32'h14;
    model_step();
    @(negedge clk);
    for (int s = 0; s < 300; s++) begin
      int len;
      len        = $urandom_range(1, 9);
      key_step_n = ($urandom_range(0, 1) == 0);
      key_run_n  = ($urandom_range(0, 2) != 0);
      sw_fast    = ($urandom_range(0, 1) == 0);
      reset      = ($urandom_range(0, 39) == 0);
      bp_en      = ($urandom_range(0, 1) == 0);
      pc         = ($urandom_range(0, 1) == 0) ? 32'h10 : 32'h14;
      for (int c = 0; c < len; c++) begin
        model_step();
        @(negedge clk);
        check($sformatf("rnd%0d cpu_en", s), 32'(cpu_en), 32'(m_cpu));
        check($sformatf("rnd%0d run_state", s), 32'(run_state), 32'(m_state));
        check($sformatf("rnd%0d instr_count", s), 32'(instr_count), 32'(m_cnt));
      end
      $display("seg %0d: len=%0d ks=%0b kr=%0b sw=%0b rst=%0b bp_en=%0b pc=%0h -> state=%0d count=%0d",
               s, len, key_step_n, key_run_n, sw_fast, reset, bp_en, pc, run_state, instr_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
